tinyqv_lsu: RTL and testbench

TINYQV_LSU -- requirements
Module: tinyqv_lsu

---
 rtl/tinyqv_lsu.sv | 161 ++++++++++++++++
 tb/tb_tinyqv_lsu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_lsu.sv
// Load/store unit bridging the nibble-serial TinyQV core to a 32-bit word bus.
// Loads are streamed back one nibble per counter step, aligned to counter=0.
module tinyqv_lsu (
    input  logic        clk,
    input  logic        rstn,

    input  logic [2:0]  counter,
    input  logic        address_ready,
    input  logic [27:0] addr_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  mem_op,
    input  logic [3:0]  store_nibble,

    output logic [3:0]  data_in,
    output logic        load_data_ready,
    output logic        busy,
    output logic        misaligned,

    output logic [27:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        HOLD   = 3'd3,
        STREAM = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [27:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wbuf;
    logic [31:0] rbuf;
    logic        misaligned_q;
    logic        start;
    logic        misalign_in;
    logic [4:0]  byte_shift;

    // Sign/zero extension is done by the core, so the unsigned flag is not needed here.
    logic        unused_op_sign;
    assign unused_op_sign = mem_op[2];

    assign start       = (state == IDLE) && address_ready && (is_load || is_store);
    assign misalign_in = ((mem_op[1:0] == 2'b01) && addr_in[0]) ||
                         (mem_op[1] && (addr_in[1:0] != 2'b00));
    assign byte_shift  = {addr_q[1:0], 3'b000};
    assign misaligned  = misaligned_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !misalign_in) begin
                    state_next = is_load ? READ : WRITE;
                end
            end
            READ: begin
                if (mem_ready) begin
                    state_next = HOLD;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (counter == 3'd7) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (counter == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The store buffer fills while idle, so on address_ready it already holds this cycle's nibble.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            misaligned_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wbuf         <= '0;
            rbuf         <= '0;
        end else begin
            misaligned_q <= start && misalign_in;
            if ((state == IDLE) && is_store) begin
                wbuf[{counter, 2'b00} +: 4] <= store_nibble;
            end
            if (start) begin
                addr_q <= addr_in;
                size_q <= mem_op[1:0];
            end
            if ((state == READ) && mem_ready) begin
                rbuf <= mem_rdata >> byte_shift;
            end
        end
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        busy            = 1'b0;
        load_data_ready = 1'b0;
        data_in         = '0;
        case (state)
            READ: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[27:2], 2'b00};
                busy     = 1'b1;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[27:2], 2'b00};
                mem_wdata = wbuf << byte_shift;
                case (size_q)
                    2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
                    2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
                    default: mem_wstrb = 4'b1111;
                endcase
                busy = 1'b1;
            end
            HOLD: begin
                busy = 1'b1;
            end
            STREAM: begin
                busy            = 1'b1;
                load_data_ready = 1'b1;
                data_in         = rbuf[{counter, 2'b00} +: 4];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tinyqv_lsu.sv
// Directed bench for tinyqv_lsu: expected load nibbles (with their cycle) are queued
// when the bus response is driven and compared every cycle against the stream.
module tb_tinyqv_lsu;

    logic        clk;
    logic        rstn;
    logic [2:0]  counter;
    logic        address_ready;
    logic [27:0] addr_in;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_op;
    logic [3:0]  store_nibble;
    logic [3:0]  data_in;
    logic        load_data_ready;
    logic        busy;
    logic        misaligned;
    logic [27:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    typedef struct {
        logic [3:0] nib;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    tinyqv_lsu dut (
        .clk             (clk),
        .rstn            (rstn),
        .counter         (counter),
        .address_ready   (address_ready),
        .addr_in         (addr_in),
        .is_load         (is_load),
        .is_store        (is_store),
        .mem_op          (mem_op),
        .store_nibble    (store_nibble),
        .data_in         (data_in),
        .load_data_ready (load_data_ready),
        .busy            (busy),
        .misaligned      (misaligned),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; the core's counter runs freely and the load stream is checked every cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        counter = counter + 3'd1;
        #1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check_output("stream nibble", {27'd0, load_data_ready, data_in}, {27'd0, 1'b1, e.nib});
        end else begin
            check_output("stream quiet", {27'd0, load_data_ready, data_in}, 32'd0);
        end
    endtask

    task automatic wait_counter(input logic [2:0] c);
        while (counter != c) tick();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) tick();
        check_output({tag, " stream left"}, exp_q.size(), 32'd0);
        exp_q.delete();
        tick();
        check_output({tag, " busy after"}, busy, 32'd0);
    endtask

    task automatic apply_stimulus(input string tag, input logic [27:0] addr, input logic [2:0] op,
                                  input logic [31:0] rdata, input logic [27:0] exp_addr,
                                  input logic [31:0] exp_rbuf, input int wait_cyc,
                                  input logic [2:0] start_cnt, input bit poke);
        int t;
        int d;
        int first;
        wait_counter(start_cnt);
        address_ready = 1'b1;
        is_load       = 1'b1;
        addr_in       = addr;
        mem_op        = op;
        tick();
        address_ready = 1'b0;
        is_load       = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            check_output({tag, " mem_read"}, mem_read, 32'd1);
            check_output({tag, " mem_addr"}, mem_addr, exp_addr);
            check_output({tag, " mem_write"}, mem_write, 32'd0);
            check_output({tag, " busy"}, busy, 32'd1);
            if (poke && i == 0) begin
                address_ready = 1'b1;
                is_store      = 1'b1;
                addr_in       = 28'h0000500;
                mem_op        = 3'b010;
            end else begin
                address_ready = 1'b0;
                is_store      = 1'b0;
            end
            if (i == wait_cyc - 1) begin
                mem_rdata = rdata;
                mem_ready = 1'b1;
                // Stream begins at the first counter=0 after at least one HOLD cycle.
                t     = cyc;
                d     = (int'(counter) + 1) % 8;
                first = t + 9 - d;
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back('{nib: exp_rbuf[4*k +: 4], cyc: first + k});
                end
            end
            tick();
        end
        mem_ready     = 1'b0;
        mem_rdata     = 32'hDEADBEEF;
        address_ready = 1'b0;
        is_store      = 1'b0;
        check_output({tag, " mem_read off"}, mem_read, 32'd0);
        check_output({tag, " mem_write off"}, mem_write, 32'd0);
        check_output({tag, " busy hold"}, busy, 32'd1);
        drain(tag);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rstn          = 1'b0;
        counter       = 3'd0;
        address_ready = 1'b0;
        addr_in       = '0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        mem_op        = '0;
        store_nibble  = '0;
        mem_rdata     = '0;
        mem_ready     = 1'b0;

        repeat (3) tick();
        check_output("rst mem_read", mem_read, 32'd0);
        check_output("rst mem_write", mem_write, 32'd0);
        check_output("rst busy", busy, 32'd0);
        check_output("rst misaligned", misaligned, 32'd0);
        check_output("rst mem_addr", mem_addr, 32'd0);
        check_output("rst mem_wdata", mem_wdata, 32'd0);
        check_output("rst mem_wstrb", mem_wstrb, 32'd0);
        rstn = 1'b1;
        tick();

        $display("[TB] word load");
        apply_stimulus("word", 28'h0000100, 3'b010, 32'h89ABCDEF, 28'h0000100, 32'h89ABCDEF, 3, 3'd2, 1'b0);

        $display("[TB] byte store");
        wait_counter(3'd0);
        is_store = 1'b1;
        mem_op   = 3'b000;
        addr_in  = 28'h0000203;
        for (int i = 0; i < 8; i++) begin
            store_nibble  = (i == 0) ? 4'h5 : (i == 1) ? 4'hA : 4'h0;
            address_ready = (i == 7);
            tick();
        end
        is_store      = 1'b0;
        address_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check_output("store mem_write", mem_write, 32'd1);
            check_output("store mem_read", mem_read, 32'd0);
            check_output("store mem_addr", mem_addr, 32'h0000200);
            check_output("store mem_wdata", mem_wdata, 32'hA5000000);
            check_output("store mem_wstrb", mem_wstrb, 32'b1000);
            check_output("store busy", busy, 32'd1);
            mem_ready = (j == 2);
            tick();
        end
        mem_ready = 1'b0;
        check_output("store mem_write off", mem_write, 32'd0);
        check_output("store busy off", busy, 32'd0);
        repeat (10) tick();

        $display("[TB] half load");
        apply_stimulus("half", 28'h0000006, 3'b001, 32'h1234ABCD, 28'h0000004, 32'h00001234, 1, 3'd0, 1'b0);

        $display("[TB] misaligned word load");
        address_ready = 1'b1;
        is_load       = 1'b1;
        addr_in       = 28'h0000102;
        mem_op        = 3'b010;
        tick();
        address_ready = 1'b0;
        is_load       = 1'b0;
        check_output("misal pulse", misaligned, 32'd1);
        check_output("misal busy", busy, 32'd0);
        check_output("misal mem_read", mem_read, 32'd0);
        tick();
        check_output("misal pulse end", misaligned, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_output("misal no read", {30'd0, mem_read, busy}, 32'd0);
            tick();
        end

        $display("[TB] reset during read");
        address_ready = 1'b1;
        is_load       = 1'b1;
        addr_in       = 28'h0000300;
        mem_op        = 3'b010;
        tick();
        address_ready = 1'b0;
        is_load       = 1'b0;
        check_output("rstread mem_read", mem_read, 32'd1);
        rstn = 1'b0;
        tick();
        check_output("rstread mem_read off", mem_read, 32'd0);
        check_output("rstread busy off", busy, 32'd0);
        rstn      = 1'b1;
        mem_rdata = 32'h11111111;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check_output("rstread stray ready", {30'd0, mem_read, busy}, 32'd0);
        apply_stimulus("after rst", 28'h0000040, 3'b010, 32'h76543210, 28'h0000040, 32'h76543210, 2, 3'd1, 1'b0);

        $display("[TB] ready on counter 7 with ignored request");
        apply_stimulus("cnt7", 28'h0000804, 3'b110, 32'hCAFE1234, 28'h0000804, 32'hCAFE1234, 2, 3'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_output("cnt7 no write", {30'd0, mem_write, busy}, 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
